// File: rtl/dco_pkg.sv
// Shared types and default constants for the DCO frequency-locked-loop controller.
// Contents: fll_state_e (controller state encoding), default parameter values,
// and a small max helper used for sizing the phase timer.
package dco_pkg;

   typedef enum logic [2:0] {
      IDLE,
      SETTLE,
      MEASURE,
      EVAL,
      DONE,
      TRACK
   } fll_state_e;

   localparam int CODE_W_DEF     = 8;
   localparam int CNT_W_DEF      = 16;
   localparam int WIN_LOG2_DEF   = 10;
   localparam int SETTLE_CYC_DEF = 16;
   localparam int TOL_DEF        = 2;
   localparam int LOCK_N_DEF     = 4;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/dco_edge_sync.sv
// Brings the free-running DCO output into the clk domain and produces a
// one-cycle pulse per rising edge. Runs continuously, independent of the FSM.
// Ports:
//   clk      system clock
//   rst_n    asynchronous active-low reset
//   async_in DCO output, asynchronous to clk (must be below clk/2)
//   edge_o   one-cycle pulse per synchronized rising edge
module dco_edge_sync (
   input  logic clk,
   input  logic rst_n,
   input  logic async_in,
   output logic edge_o
);

   logic sync1_q;
   logic sync2_q;
   logic prev_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         prev_q  <= 1'b0;
      end else begin
         sync1_q <= async_in;
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
      end
   end

   assign edge_o = sync2_q & ~prev_q;

endmodule

// File: rtl/dco_fll_ctrl.sv
// Frequency-locked-loop controller for the 8-bit DCO. Counts DCO edges over a
// 2**WIN_LOG2 clk window, runs an MSB-first successive-approximation search on
// dco_code, then either freezes (DONE) or keeps tracking (TRACK).
// Build option: define DCO_FLL_TRACK_EN to enable continuous tracking after the
// search; without it the loop stops in DONE and the tracking logic is absent.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   ena          block enable; low returns to IDLE (code is held)
//   start        pulse: start or restart the search from the MSB
//   target       desired edge count per window
//   dco_in       DCO output (asynchronous)
//   dco_code     code driven to the DCO
//   busy         search in progress
//   locked       loop within TOL (DONE: final window; TRACK: LOCK_N in a row)
//   meas_count   last completed window count
//   meas_valid   one-cycle pulse when meas_count updates
//
// state   | meaning
// IDLE    | waiting for start with ena high
// SETTLE  | SETTLE_CYC cycles for the DCO to respond to a new code
// MEASURE | counting DCO edges for 2**WIN_LOG2 cycles
// EVAL    | one cycle: publish count, update code (SAR bit or tracking step)
// DONE    | search finished, code frozen
// TRACK   | search finished, one cycle before the first tracking window
module dco_fll_ctrl
   import dco_pkg::*;
#(
   parameter int CODE_W     = CODE_W_DEF,
   parameter int CNT_W      = CNT_W_DEF,
   parameter int WIN_LOG2   = WIN_LOG2_DEF,
   parameter int SETTLE_CYC = SETTLE_CYC_DEF,
   parameter int TOL        = TOL_DEF,
   parameter int LOCK_N     = LOCK_N_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ena,
   input  logic              start,
   input  logic [CNT_W-1:0]  target,
   input  logic              dco_in,
   output logic [CODE_W-1:0] dco_code,
   output logic              busy,
   output logic              locked,
   output logic [CNT_W-1:0]  meas_count,
   output logic              meas_valid
);

   localparam int BIT_W = (CODE_W > 1) ? $clog2(CODE_W) : 1;
   localparam int TMR_W = max_int(WIN_LOG2, $clog2(SETTLE_CYC)) + 1;

   localparam logic [CODE_W-1:0] CODE_MSB   = {1'b1, {(CODE_W-1){1'b0}}};
   localparam logic [BIT_W-1:0]  BIT_TOP    = BIT_W'(CODE_W - 1);
   localparam logic [TMR_W-1:0]  SETTLE_TC  = TMR_W'(SETTLE_CYC - 1);
   localparam logic [TMR_W-1:0]  WIN_TC     = TMR_W'((1 << WIN_LOG2) - 1);
   localparam logic [CNT_W:0]    TOL_X      = (CNT_W+1)'(TOL);

   if (LOCK_N < 1 || SETTLE_CYC < 1) begin : g_bad_cfg
      $error("dco_fll_ctrl: LOCK_N and SETTLE_CYC must be at least 1");
   end

   fll_state_e         state_q, state_d;
   logic [CODE_W-1:0]  code_q, code_d;
   logic [BIT_W-1:0]   bit_q, bit_d;
   logic [TMR_W-1:0]   tmr_q, tmr_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [CNT_W-1:0]   meas_q, meas_d;
   logic               busy_q, busy_d;
   logic               locked_q, locked_d;
   logic               valid_q, valid_d;
   logic               dco_edge;
   logic               sar_phase;
   logic               above, below;

`ifdef DCO_FLL_TRACK_EN
   localparam int RUN_W = $clog2(LOCK_N + 1);
   logic               track_q, track_d;
   logic [RUN_W-1:0]   run_q, run_d;
   assign sar_phase = ~track_q;
`else
   assign sar_phase = 1'b1;
`endif

   dco_edge_sync u_edge_sync (
      .clk      (clk),
      .rst_n    (rst_n),
      .async_in (dco_in),
      .edge_o   (dco_edge)
   );

   // One extra bit so target+TOL and count+TOL never wrap.
   assign above = {1'b0, cnt_q} > ({1'b0, target} + TOL_X);
   assign below = ({1'b0, cnt_q} + TOL_X) < {1'b0, target};

   always_comb begin
      state_d  = state_q;
      code_d   = code_q;
      bit_d    = bit_q;
      tmr_d    = tmr_q;
      cnt_d    = cnt_q;
      meas_d   = meas_q;
      busy_d   = busy_q;
      locked_d = locked_q;
      valid_d  = 1'b0;
`ifdef DCO_FLL_TRACK_EN
      track_d  = track_q;
      run_d    = run_q;
`endif
      if (!ena) begin
         // ena low wins over start in the same cycle; code is held.
         state_d  = IDLE;
         busy_d   = 1'b0;
         locked_d = 1'b0;
      end else if (start) begin
         state_d  = SETTLE;
         tmr_d    = SETTLE_TC;
         code_d   = CODE_MSB;
         bit_d    = BIT_TOP;
         busy_d   = 1'b1;
         locked_d = 1'b0;
`ifdef DCO_FLL_TRACK_EN
         track_d  = 1'b0;
         run_d    = '0;
`endif
      end else begin
         case (state_q)
            SETTLE: begin
               if (tmr_q == '0) begin
                  state_d = MEASURE;
                  tmr_d   = WIN_TC;
                  cnt_d   = '0;
               end else begin
                  tmr_d = tmr_q - 1'b1;
               end
            end
            MEASURE: begin
               if (dco_edge && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
               if (tmr_q == '0) state_d = EVAL;
               else             tmr_d   = tmr_q - 1'b1;
            end
            EVAL: begin
               meas_d  = cnt_q;
               valid_d = 1'b1;
               if (sar_phase) begin
                  if (cnt_q > target) code_d[bit_q] = 1'b0;
                  if (bit_q != '0) begin
                     bit_d                 = bit_q - 1'b1;
                     code_d[bit_q - 1'b1]  = 1'b1;
                     state_d               = SETTLE;
                     tmr_d                 = SETTLE_TC;
                  end else begin
                     busy_d = 1'b0;
`ifdef DCO_FLL_TRACK_EN
                     state_d = TRACK;
                     track_d = 1'b1;
                     run_d   = '0;
`else
                     state_d  = DONE;
                     locked_d = ~above & ~below;
`endif
                  end
               end else begin
`ifdef DCO_FLL_TRACK_EN
                  state_d = SETTLE;
                  tmr_d   = SETTLE_TC;
                  if (above) begin
                     if (code_q != '0) code_d = code_q - 1'b1;
                     locked_d = 1'b0;
                     run_d    = '0;
                  end else if (below) begin
                     if (code_q != '1) code_d = code_q + 1'b1;
                     locked_d = 1'b0;
                     run_d    = '0;
                  end else if (run_q >= RUN_W'(LOCK_N - 1)) begin
                     locked_d = 1'b1;
                  end else begin
                     run_d = run_q + 1'b1;
                  end
`endif
               end
            end
            DONE: ;
`ifdef DCO_FLL_TRACK_EN
            TRACK: begin
               state_d = SETTLE;
               tmr_d   = SETTLE_TC;
            end
`endif
            IDLE: ;
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         code_q   <= CODE_MSB;
         bit_q    <= BIT_TOP;
         tmr_q    <= '0;
         cnt_q    <= '0;
         meas_q   <= '0;
         busy_q   <= 1'b0;
         locked_q <= 1'b0;
         valid_q  <= 1'b0;
`ifdef DCO_FLL_TRACK_EN
         track_q  <= 1'b0;
         run_q    <= '0;
`endif
      end else begin
         state_q  <= state_d;
         code_q   <= code_d;
         bit_q    <= bit_d;
         tmr_q    <= tmr_d;
         cnt_q    <= cnt_d;
         meas_q   <= meas_d;
         busy_q   <= busy_d;
         locked_q <= locked_d;
         valid_q  <= valid_d;
`ifdef DCO_FLL_TRACK_EN
         track_q  <= track_d;
         run_q    <= run_d;
`endif
      end
   end

   assign dco_code   = code_q;
   assign busy       = busy_q;
   assign locked     = locked_q;
   assign meas_count = meas_q;
   assign meas_valid = valid_q;

endmodule

// File: tb/tb_dco_fll_ctrl.sv
// Directed bench for dco_fll_ctrl at default parameters. The DCO model emits
// exactly (dco_code + offset) single-cycle pulses per 1024-cycle period at fixed
// phases, so any full measurement window sees exactly that many rising edges.
// Tracking scenario is compiled when DCO_FLL_TRACK_EN is defined.
module tb_dco_fll_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        ena = 1'b0;
   logic        start = 1'b0;
   logic [15:0] target = '0;
   logic        dco_in = 1'b0;
   logic [7:0]  dco_code;
   logic        busy;
   logic        locked;
   logic [15:0] meas_count;
   logic        meas_valid;

   int errors = 0;
   int checks = 0;
   int offset = 0;
   int phase  = 0;

`ifdef DCO_FLL_TRACK_EN
   localparam logic LOCK_AFTER_100  = 1'b0;
   localparam logic LOCK_AFTER_ZERO = 1'b0;
`else
   localparam logic LOCK_AFTER_100  = 1'b1;
   localparam logic LOCK_AFTER_ZERO = 1'b1;
`endif

   dco_fll_ctrl dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .ena        (ena),
      .start      (start),
      .target     (target),
      .dco_in     (dco_in),
      .dco_code   (dco_code),
      .busy       (busy),
      .locked     (locked),
      .meas_count (meas_count),
      .meas_valid (meas_valid)
   );

   always #5 clk = ~clk;

   // DCO model: n pulses per 1024 cycles, never on adjacent cycles (n <= 512).
   always @(negedge clk) begin
      int n;
      n = int'(dco_code) + offset;
      if (n < 0)   n = 0;
      if (n > 512) n = 512;
      phase  = (phase + 1) % 1024;
      dco_in = (((phase + 1) * n) / 1024) != ((phase * n) / 1024);
   end

   initial begin
      #1500000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
      $fatal(1, "watchdog");
   end

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic run_sar(output int cyc, output int pulses);
      pulse_start();
      cyc = 0;
      pulses = 0;
      while (busy && cyc < 9000) begin
         @(posedge clk);
         #1;
         cyc++;
         if (meas_valid) pulses++;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #23;
      checks++; if (dco_code !== 8'h80) begin errors++; $display("FAIL reset_code: got %h want 80", dco_code); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
      checks++; if (locked !== 1'b0) begin errors++; $display("FAIL reset_locked: got %b want 0", locked); end
      checks++; if (meas_count !== 16'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", meas_count); end
      checks++; if (meas_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", meas_valid); end
      @(negedge clk);
      rst_n = 1'b1;
      ena   = 1'b1;
      tick(2);
   endtask

   task automatic test_sar();
      int cyc, pulses;
      target = 16'd100;
      run_sar(cyc, pulses);
      checks++; if (cyc != 8328) begin errors++; $display("FAIL sar_cycles: got %0d want 8328", cyc); end
      checks++; if (pulses != 8) begin errors++; $display("FAIL sar_pulses: got %0d want 8", pulses); end
      checks++; if (dco_code !== 8'd100) begin errors++; $display("FAIL sar_code: got %0d want 100", dco_code); end
      checks++; if (meas_count !== 16'd101) begin errors++; $display("FAIL sar_last_count: got %0d want 101", meas_count); end
      checks++; if (locked !== LOCK_AFTER_100) begin errors++; $display("FAIL sar_locked: got %b want %b", locked, LOCK_AFTER_100); end
   endtask

   task automatic test_boundary();
      int cyc, pulses;
      target = 16'd0;
      run_sar(cyc, pulses);
      checks++; if (dco_code !== 8'h00) begin errors++; $display("FAIL tgt0_code: got %h want 00", dco_code); end
      checks++; if (meas_count !== 16'd1) begin errors++; $display("FAIL tgt0_count: got %0d want 1", meas_count); end
      checks++; if (locked !== LOCK_AFTER_ZERO) begin errors++; $display("FAIL tgt0_locked: got %b want %b", locked, LOCK_AFTER_ZERO); end
      target = 16'hFFFF;
      run_sar(cyc, pulses);
      checks++; if (dco_code !== 8'hFF) begin errors++; $display("FAIL tgtmax_code: got %h want ff", dco_code); end
      checks++; if (meas_count !== 16'd255) begin errors++; $display("FAIL tgtmax_count: got %0d want 255", meas_count); end
      checks++; if (locked !== 1'b0) begin errors++; $display("FAIL tgtmax_locked: got %b want 0", locked); end
      checks++; if (cyc != 8328) begin errors++; $display("FAIL tgtmax_cycles: got %0d want 8328", cyc); end
   endtask

   task automatic test_ena_restart();
      int n, pulses;
      target = 16'd100;
      pulse_start();
      tick(2500);
      checks++; if (dco_code !== 8'h60) begin errors++; $display("FAIL midsar_code: got %h want 60", dco_code); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midsar_busy: got %b want 1", busy); end
      @(negedge clk);
      ena = 1'b0;
      tick(1);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL enalow_busy: got %b want 0", busy); end
      checks++; if (dco_code !== 8'h60) begin errors++; $display("FAIL enalow_code: got %h want 60", dco_code); end
      pulse_start();
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL start_enalow_busy: got %b want 0", busy); end
      pulses = 0;
      for (int i = 0; i < 1100; i++) begin
         tick(1);
         if (meas_valid) pulses++;
      end
      checks++; if (pulses != 0) begin errors++; $display("FAIL idle_valid: got %0d pulses want 0", pulses); end
      checks++; if (dco_code !== 8'h60) begin errors++; $display("FAIL idle_code_hold: got %h want 60", dco_code); end
      ena = 1'b1;
      pulse_start();
      checks++; if (dco_code !== 8'h80 || busy !== 1'b1) begin errors++; $display("FAIL restart_idle: got code %h busy %b want 80/1", dco_code, busy); end
      tick(1500);
      checks++; if (dco_code !== 8'h40) begin errors++; $display("FAIL trial1_code: got %h want 40", dco_code); end
      pulse_start();
      checks++; if (dco_code !== 8'h80 || busy !== 1'b1) begin errors++; $display("FAIL restart_busy: got code %h busy %b want 80/1", dco_code, busy); end
      n = 0;
      while (!meas_valid && n < 2000) begin
         tick(1);
         n++;
      end
      checks++; if (n != 1041) begin errors++; $display("FAIL restart_latency: got %0d want 1041", n); end
      checks++; if (meas_count !== 16'd128) begin errors++; $display("FAIL restart_count: got %0d want 128", meas_count); end
      checks++; if (dco_code !== 8'h40) begin errors++; $display("FAIL restart_code: got %h want 40", dco_code); end
   endtask

   task automatic test_async_reset();
      target = 16'd100;
      pulse_start();
      tick(1500);
      checks++; if (dco_code !== 8'h40 || busy !== 1'b1) begin errors++; $display("FAIL prereset_state: got code %h busy %b want 40/1", dco_code, busy); end
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      checks++; if (dco_code !== 8'h80) begin errors++; $display("FAIL arst_code: got %h want 80", dco_code); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL arst_busy: got %b want 0", busy); end
      checks++; if (meas_count !== 16'd0) begin errors++; $display("FAIL arst_count: got %0d want 0", meas_count); end
      checks++; if (meas_valid !== 1'b0 || locked !== 1'b0) begin errors++; $display("FAIL arst_flags: got valid %b locked %b want 0/0", meas_valid, locked); end
      @(negedge clk);
      rst_n = 1'b1;
      tick(2);
   endtask

`ifdef DCO_FLL_TRACK_EN
   task automatic test_track();
      int cyc, pulses;
      offset = 0;
      target = 16'd100;
      run_sar(cyc, pulses);
      checks++; if (dco_code !== 8'd100 || locked !== 1'b0) begin errors++; $display("FAIL trk_sar: got code %0d locked %b want 100/0", dco_code, locked); end
      cyc = 0; pulses = 0;
      while (!locked && cyc < 6000) begin
         tick(1); cyc++;
         if (meas_valid) pulses++;
      end
      checks++; if (pulses != 4 || !locked) begin errors++; $display("FAIL trk_lock: got %0d windows locked %b want 4/1", pulses, locked); end
      cyc = 0;
      while (!meas_valid && cyc < 1200) begin tick(1); cyc++; end
      offset = -10;
      cyc = 0;
      do begin tick(1); cyc++; end while (!meas_valid && cyc < 1200);
      checks++; if (meas_count !== 16'd90 || locked !== 1'b0 || dco_code !== 8'd101) begin
         errors++; $display("FAIL trk_step: got count %0d locked %b code %0d want 90/0/101", meas_count, locked, dco_code);
      end
      cyc = 0; pulses = 0;
      while (!locked && cyc < 15000) begin
         tick(1); cyc++;
         if (meas_valid) pulses++;
      end
      checks++; if (pulses != 11 || !locked) begin errors++; $display("FAIL trk_relock: got %0d windows locked %b want 11/1", pulses, locked); end
      checks++; if (dco_code !== 8'd108 || meas_count !== 16'd98) begin errors++; $display("FAIL trk_final: got code %0d count %0d want 108/98", dco_code, meas_count); end
      offset = 0;
   endtask
`endif

   initial begin
      test_reset();
      test_sar();
      test_boundary();
      test_ena_restart();
      test_async_reset();
`ifdef DCO_FLL_TRACK_EN
      test_track();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
